crc_engine: RTL

//  Dual-channel CRC-16 coprocessor that consumes the CRC control/data fields held in the peripheral register RAM
//  (enable, init values, input bytes) and returns results and status for write-back.

---
 rtl/crc_pkg.sv | 40 ++++
 rtl/crc_channel.sv | 104 ++++++++++
 rtl/crc_engine.sv | 61 ++++++
 3 files changed

// File: rtl/crc_pkg.sv
// Shared constants and helpers for the dual-channel CRC-16 coprocessor.
// Consumers switch between bit-serial and byte-folding engines with CRC_FAST_EN.
package crc_pkg;

    localparam int CRC_W  = 16;
    localparam int DATA_W = 8;
    localparam int CNT_W  = $clog2(DATA_W);
    localparam logic [CRC_W-1:0] POLY = 16'h1021;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } crc_state_e;

    localparam int STAT_BUSY1 = 0;
    localparam int STAT_BUSY2 = 1;
    localparam int STAT_DONE1 = 2;
    localparam int STAT_DONE2 = 3;
    localparam int STAT_OVF1  = 4;
    localparam int STAT_OVF2  = 5;

    // One MSB-first, non-reflected LFSR step.
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc,
                                                  input logic             din);
        logic fb;
        fb = crc[CRC_W-1] ^ din;
        return {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    endfunction

    function automatic logic [CRC_W-1:0] crc_byte(input logic [CRC_W-1:0]  crc,
                                                  input logic [DATA_W-1:0] din);
        logic [CRC_W-1:0] c;
        c = crc;
        for (int k = DATA_W - 1; k >= 0; k--) begin
            c = crc_step(c, din[k]);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc_channel.sv
// One CRC-16 channel: valid/ready byte intake, shift FSM, sticky overflow, done pulse.
// CRC_FAST_EN folds the whole byte in a single SHIFT cycle instead of eight.
//   state    | meaning
//   ST_IDLE  | waiting for a byte (ready when enabled and no init strobe)
//   ST_SHIFT | folding the latched byte into the CRC register
module crc_channel
    import crc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              init_strb_i,
    input  logic [CRC_W-1:0]  init_i,
    input  logic              data_valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              data_ready_o,
    output logic [CRC_W-1:0]  crc_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              ovf_o
);

    crc_state_e        state_q, state_d;
    logic [CRC_W-1:0]  crc_q, crc_d;
    logic [DATA_W-1:0] byte_q, byte_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              can_take;

`ifdef CRC_FAST_EN
    assign can_take = (state_q == ST_IDLE);
`else
    // Intake reopens during the final bit so the next byte overlaps the last shift.
    assign can_take = (state_q == ST_IDLE) || (bit_cnt_q == '0);
`endif

    assign data_ready_o = en_i && !init_strb_i && !rst && can_take;

    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        byte_d    = byte_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q;
        if (init_strb_i) begin
            state_d = ST_IDLE;
            crc_d   = init_i;
            ovf_d   = 1'b0;
        end else begin
            if (data_valid_i && !data_ready_o) begin
                ovf_d = 1'b1;
            end
            if (state_q == ST_SHIFT) begin
                if (!en_i) begin
                    state_d = ST_IDLE;
                end else begin
`ifdef CRC_FAST_EN
                    crc_d   = crc_byte(crc_q, byte_q);
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
`else
                    crc_d     = crc_step(crc_q, byte_q[bit_cnt_q]);
                    bit_cnt_d = bit_cnt_q - 1'b1;
                    if (bit_cnt_q == '0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
`endif
                end
            end
            if (data_valid_i && data_ready_o) begin
                state_d   = ST_SHIFT;
                byte_d    = data_i;
                bit_cnt_d = CNT_W'(DATA_W - 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            crc_q     <= '0;
            byte_q    <= '0;
            bit_cnt_q <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            byte_q    <= byte_d;
            bit_cnt_q <= bit_cnt_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
        end
    end

    assign crc_o  = crc_q;
    assign busy_o = (state_q == ST_SHIFT);
    assign done_o = done_q;
    assign ovf_o  = ovf_q;

endmodule

// File: rtl/crc_engine.sv
// Dual-channel CRC-16 coprocessor: two independent crc_channel instances plus status packing.
// Build option CRC_FAST_EN selects single-cycle byte folding in both channels.
module crc_engine
    import crc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        i_en,
    input  logic [1:0]        i_init_strb,
    input  logic [CRC_W-1:0]  i_init1,
    input  logic [CRC_W-1:0]  i_init2,
    input  logic [1:0]        i_data_valid,
    input  logic [DATA_W-1:0] i_data1,
    input  logic [DATA_W-1:0] i_data2,
    output logic [1:0]        o_data_ready,
    output logic [CRC_W-1:0]  o_crc1,
    output logic [CRC_W-1:0]  o_crc2,
    output logic [7:0]        o_stat
);

    logic [1:0] busy, done, ovf;

    crc_channel u_ch1 (
        .clk          (clk),
        .rst          (rst),
        .en_i         (i_en[0]),
        .init_strb_i  (i_init_strb[0]),
        .init_i       (i_init1),
        .data_valid_i (i_data_valid[0]),
        .data_i       (i_data1),
        .data_ready_o (o_data_ready[0]),
        .crc_o        (o_crc1),
        .busy_o       (busy[0]),
        .done_o       (done[0]),
        .ovf_o        (ovf[0])
    );

    crc_channel u_ch2 (
        .clk          (clk),
        .rst          (rst),
        .en_i         (i_en[1]),
        .init_strb_i  (i_init_strb[1]),
        .init_i       (i_init2),
        .data_valid_i (i_data_valid[1]),
        .data_i       (i_data2),
        .data_ready_o (o_data_ready[1]),
        .crc_o        (o_crc2),
        .busy_o       (busy[1]),
        .done_o       (done[1]),
        .ovf_o        (ovf[1])
    );

    assign o_stat[STAT_BUSY1] = busy[0];
    assign o_stat[STAT_BUSY2] = busy[1];
    assign o_stat[STAT_DONE1] = done[0];
    assign o_stat[STAT_DONE2] = done[1];
    assign o_stat[STAT_OVF1]  = ovf[0];
    assign o_stat[STAT_OVF2]  = ovf[1];
    assign o_stat[7:6]        = 2'b00;

endmodule
